// File: rtl/eth_mdio_pkg.sv
// Shared types, frame constants and the frame builder for the clause 22 MDIO master.
package eth_mdio_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} mdio_state_e;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    // Bit positions inside the 32-bit ST..DATA header.
    localparam int TA_POS   = 16;
    localparam int DATA_POS = 0;

    // Full 32 preamble ones on top; shorter preambles just start lower in the word.
    function automatic logic [63:0] mdio_frame(input logic rd, input logic [4:0] phyad,
                                               input logic [4:0] regad, input logic [15:0] wdata);
        logic [31:0] hdr;
        hdr = {MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR), phyad, regad,
               (rd ? 2'b00 : MDIO_TA_WR), (rd ? 16'h0000 : wdata)};
        return {32'hFFFF_FFFF, hdr};
    endfunction

endpackage

// File: rtl/eth_mdio_master_tick.sv
// MDC generator: half-period counter, MDC level and one-cycle rise/fall strobes.
module mdio_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic mdc
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = en & wrap & ~mdc;
    assign fall_tick = en & wrap & mdc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) mdc <= ~mdc;
        end
    end
endmodule

// File: rtl/eth_mdio_master.sv
// Clause 22 MDIO master: serialises one read/write frame, returns read data,
// and muxes a legacy bit-bang path onto the pads while idle.
module eth_mdio_master #(
    parameter int CLK_DIV  = 25,
    parameter int PRE_BITS = 32
) (
    input  logic        msoc_clk,
    input  logic        rst_int,
    input  logic        cmd_start,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    input  logic        bb_en,
    input  logic        bb_mdc,
    input  logic        bb_mdio_o,
    input  logic        bb_mdio_oen,
    input  logic        phy_mdio_i,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oen,
    output logic        phy_mdc
);
    import eth_mdio_pkg::*;

    localparam int N = PRE_BITS + 32;

    mdio_state_e state, state_nx;
    logic        accept, shifting, last_fall;
    logic        rise_tick, fall_tick, mdc;
    logic        rd_q;
    logic [63:0] frame, sr;
    logic [5:0]  bitcnt;
    logic [1:0]  sync;
    logic [15:0] rd_sr;

    assign frame     = mdio_frame(cmd_read, cmd_phyad, cmd_regad, cmd_wdata);
    assign accept    = (state == IDLE) & cmd_start;
    assign shifting  = (state == SHIFT);
    assign last_fall = fall_tick & (bitcnt == 6'd0);
    assign busy      = shifting;
    assign done      = (state == DONE);

    mdio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (msoc_clk),
        .rst       (rst_int),
        .clr       (accept),
        .en        (shifting),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .mdc       (mdc)
    );

    always_ff @(posedge msoc_clk or posedge rst_int) begin
        if (rst_int) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_start) state_nx = SHIFT;
            SHIFT:   if (last_fall) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge msoc_clk or posedge rst_int) begin
        if (rst_int) sync <= 2'b00;
        else         sync <= {sync[0], phy_mdio_i};
    end

    // sr holds the bits still to be sent; the first bit goes straight to the pad.
    always_ff @(posedge msoc_clk or posedge rst_int) begin
        if (rst_int) begin
            sr     <= '0;
            bitcnt <= '0;
            rd_q   <= 1'b0;
            rd_sr  <= '0;
            rdata  <= '0;
        end else if (accept) begin
            sr     <= frame << 1;
            bitcnt <= 6'(N - 1);
            rd_q   <= cmd_read;
        end else if (shifting) begin
            if (rise_tick && rd_q && bitcnt < 6'(DATA_POS + 16))
                rd_sr <= {rd_sr[14:0], sync[1]};
            if (fall_tick && !last_fall) begin
                sr     <= sr << 1;
                bitcnt <= bitcnt - 6'd1;
            end
            if (last_fall && rd_q) rdata <= rd_sr;
        end
    end

    // Pads are registered; bit-bang values pass through only outside a frame.
    always_ff @(posedge msoc_clk or posedge rst_int) begin
        if (rst_int) begin
            phy_mdc      <= 1'b0;
            phy_mdio_o   <= 1'b0;
            phy_mdio_oen <= 1'b1;
        end else if (accept) begin
            phy_mdc      <= 1'b0;
            phy_mdio_o   <= frame[N-1];
            phy_mdio_oen <= 1'b0;
        end else if (shifting && !last_fall) begin
            if (rise_tick)      phy_mdc <= 1'b1;
            else if (fall_tick) phy_mdc <= 1'b0;
            if (fall_tick) begin
                phy_mdio_o   <= sr[N-1];
                // The bit now starting is at position bitcnt-1; release from the first TA bit.
                phy_mdio_oen <= rd_q & (bitcnt <= 6'(TA_POS + 2));
            end
        end else if (bb_en) begin
            phy_mdc      <= bb_mdc;
            phy_mdio_o   <= bb_mdio_o;
            phy_mdio_oen <= bb_mdio_oen;
        end else begin
            phy_mdc      <= 1'b0;
            phy_mdio_o   <= 1'b0;
            phy_mdio_oen <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eth_mdio_master.sv
// Bench for eth_mdio_master: two instances (32-bit and suppressed preamble), frame-level model.
module tb_eth_mdio_master;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_w [2];
    logic        cmd_read = 1'b0;
    logic [4:0]  cmd_phyad = '0;
    logic [4:0]  cmd_regad = '0;
    logic [15:0] cmd_wdata = '0;
    logic        bb_en = 1'b0, bb_mdc = 1'b0, bb_mdio_o = 1'b0, bb_mdio_oen = 1'b1;
    logic        mdio_i = 1'b1;
    logic        busy_w [2];
    logic        done_w [2];
    logic [15:0] rdata_w [2];
    logic        mo_w [2];
    logic        oen_w [2];
    logic        mdc_w [2];
    logic [15:0] rdata_exp [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eth_mdio_master #(.CLK_DIV(CD), .PRE_BITS(32)) dut0 (
        .msoc_clk(clk), .rst_int(rst), .cmd_start(start_w[0]), .cmd_read(cmd_read),
        .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata),
        .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
        .bb_en(bb_en), .bb_mdc(bb_mdc), .bb_mdio_o(bb_mdio_o), .bb_mdio_oen(bb_mdio_oen),
        .phy_mdio_i(mdio_i), .phy_mdio_o(mo_w[0]), .phy_mdio_oen(oen_w[0]), .phy_mdc(mdc_w[0]));

    eth_mdio_master #(.CLK_DIV(CD), .PRE_BITS(0)) dut1 (
        .msoc_clk(clk), .rst_int(rst), .cmd_start(start_w[1]), .cmd_read(cmd_read),
        .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata),
        .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
        .bb_en(bb_en), .bb_mdc(bb_mdc), .bb_mdio_o(bb_mdio_o), .bb_mdio_oen(bb_mdio_oen),
        .phy_mdio_i(mdio_i), .phy_mdio_o(mo_w[1]), .phy_mdio_oen(oen_w[1]), .phy_mdc(mdc_w[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One frame on instance u; the PHY answers reads with pv. spam holds cmd_start high throughout.
    task automatic run_cmd(input int u, input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [15:0] pv, input bit spam);
        int pre, n, lim, k, done_at, done_n, err_busy, err_mdc;
        logic [31:0] hdr;
        logic [63:0] obs, oen_obs, expv, msk, oenx;
        pre = (u == 0) ? 32 : 0;
        n = pre + 32;
        lim = 2 * n * CD;
        obs = '0; oen_obs = '0;
        done_at = -1; done_n = 0; err_busy = 0; err_mdc = 0;

        hdr = 32'h4000_0000 | (rd ? 32'h2000_0000 : 32'h1000_0000) | (32'(pa) << 23) |
              (32'(ra) << 18) | (rd ? 32'h0 : ((32'h2 << 16) | 32'(wd)));
        expv = (pre == 32) ? {32'hFFFF_FFFF, hdr} : {32'h0, hdr};
        msk  = rd ? ~64'h3FFFF : '1;
        oenx = rd ? 64'h3FFFF : 64'h0;

        @(negedge clk);
        cmd_read = rd; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd;
        start_w[u] = 1'b1;
        @(posedge clk); #1;
        if (!spam) start_w[u] = 1'b0;
        chk("busy_rise", busy_w[u], 1);

        for (int c = 1; c <= lim + 6; c++) begin
            @(posedge clk); #1;
            if (spam && c == lim + 1) start_w[u] = 1'b0;
            k = c / (2 * CD);
            if (rd && c % (2 * CD) == 0 && k < n && k >= pre + 15)
                mdio_i = (k == pre + 15) ? 1'b0 : pv[n - 1 - k];
            if (c % (2 * CD) == CD && k < n) begin
                obs[n - 1 - k]     = mo_w[u];
                oen_obs[n - 1 - k] = oen_w[u];
                if (mdc_w[u] !== 1'b1) err_mdc++;
            end
            if (c % (2 * CD) == 1 && c < lim && mdc_w[u] !== 1'b0) err_mdc++;
            if (done_w[u] === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (busy_w[u] !== (c < lim)) err_busy++;
        end
        mdio_i = 1'b1;
        if (rd) rdata_exp[u] = pv;

        chk("stream", obs & msk, expv & msk);
        chk("oen", oen_obs, oenx);
        chk("done_at", done_at, lim);
        chk("done_cnt", done_n, 1);
        chk("busy_win", err_busy, 0);
        chk("mdc_shape", err_mdc, 0);
        chk("rdata", rdata_w[u], rdata_exp[u]);
    endtask

    initial begin
        int n;
        logic [2:0] prev, cur;
        start_w[0] = 1'b0; start_w[1] = 1'b0;
        rdata_exp[0] = '0; rdata_exp[1] = '0;

        #2 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++)
            chk("reset", {busy_w[u], done_w[u], mdc_w[u], mo_w[u], oen_w[u], rdata_w[u]},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0});
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_cmd(0, 0, 5'd1, 5'd0, 16'h1140, 16'h0, 0);
        run_cmd(0, 1, 5'd1, 5'd1, 16'h0, 16'h796D, 0);
        run_cmd(0, 1, 5'd2, 5'd3, 16'h0, 16'($urandom), 1);
        for (int i = 0; i < 4; i++)
            run_cmd(0, i[0], 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), 0);

        // Reset during the read data phase.
        @(negedge clk);
        cmd_read = 1'b1; cmd_phyad = 5'd3; cmd_regad = 5'd2; start_w[0] = 1'b1;
        @(posedge clk); #1 start_w[0] = 1'b0;
        repeat (2 * 58 * CD + 3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        rdata_exp[0] = '0;
        chk("rst_mid", {busy_w[0], done_w[0], mdc_w[0], mo_w[0], oen_w[0], rdata_w[0]},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (done_w[0] === 1'b1) n++;
        end
        chk("rst_no_done", n, 0);
        chk("rst_busy", busy_w[0], 0);
        run_cmd(0, 0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 0);

        // Legacy bit-bang path.
        bb_en = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        prev = {bb_mdc, bb_mdio_o, bb_mdio_oen};
        for (int i = 0; i < 6; i++) begin
            cur = 3'($urandom);
            {bb_mdc, bb_mdio_o, bb_mdio_oen} = cur;
            @(negedge clk);
            chk("bb_hold", {mdc_w[0], mo_w[0], oen_w[0]}, prev);
            @(posedge clk); #1;
            chk("bb_follow", {mdc_w[0], mo_w[0], oen_w[0]}, cur);
            prev = cur;
        end
        {bb_mdc, bb_mdio_o, bb_mdio_oen} = 3'b101;
        run_cmd(0, 0, 5'd7, 5'd9, 16'hA5C3, 16'h0, 0);
        chk("bb_after", {mdc_w[0], mo_w[0], oen_w[0]}, 3'b101);
        bb_en = 1'b0;
        @(posedge clk); #1;
        chk("idle_pads", {mdc_w[0], mo_w[0], oen_w[0]}, 3'b001);

        // Preamble suppressed.
        run_cmd(1, 0, 5'd1, 5'd0, 16'h1140, 16'h0, 0);
        run_cmd(1, 0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 0);
        run_cmd(1, 1, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
